// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer. It drives an external 1-bit ALU slice once per
// clock, LSB first, and assembles the result. SLT takes a second pass that
// writes the "less" bit through the slice.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             done,
  output logic             sl_a,
  output logic             sl_b,
  output logic             sl_ainv,
  output logic             sl_binv,
  output logic             sl_cin,
  output logic             sl_less,
  output logic [1:0]       sl_op,
  input  logic             sl_r,
  input  logic             sl_cout,
  input  logic             sl_set,
  input  logic             sl_ovf
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_NOR = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   k;
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]      op_r;
  logic            lt;
  logic            carry;
  logic            res_valid;

  logic            dec_ainv, dec_binv, dec_cin0;
  logic [1:0]      dec_op;
  logic            op_rsv, is_arith, k_last, cin_k;

  assign op_rsv   = (op_sel == 3'b011) || (op_sel == 3'b101);
  assign is_arith = (op_r == OP_ADD) || (op_r == OP_SUB) || (op_r == OP_SLT);
  assign k_last   = (k == K_LAST);
  assign cin_k    = (k == '0) ? dec_cin0 : carry;

  // zero is only meaningful once a result is complete; until then it reads 0.
  assign zero = res_valid && (result == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves the signal
    // unassigned, which would infer a latch.
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = op_rsv ? S_DONE : S_PASS1;
      S_PASS1: if (k_last) state_nx = (op_r == OP_SLT) ? S_PASS2 : S_DONE;
      S_PASS2: if (k_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Slice control decode for the first pass from the latched opcode.
  always_comb begin
    dec_ainv = 1'b0;
    dec_binv = 1'b0;
    dec_cin0 = 1'b0;
    dec_op   = 2'b00;
    case (op_r)
      OP_AND: dec_op = 2'b00;
      OP_OR:  dec_op = 2'b01;
      OP_ADD: dec_op = 2'b10;
      OP_SUB, OP_SLT: begin
        dec_binv = 1'b1;
        dec_cin0 = 1'b1;
        dec_op   = 2'b10;
      end
      OP_NOR: begin
        dec_ainv = 1'b1;
        dec_binv = 1'b1;
        dec_op   = 2'b00;
      end
      default: dec_op = 2'b00;
    endcase
  end

  // Outputs: handshake and slice drive, all slice lines quiet outside the passes.
  always_comb begin
    ready   = (state == S_IDLE);
    done    = (state == S_DONE);
    sl_a    = 1'b0;
    sl_b    = 1'b0;
    sl_ainv = 1'b0;
    sl_binv = 1'b0;
    sl_cin  = 1'b0;
    sl_less = 1'b0;
    sl_op   = 2'b00;
    case (state)
      S_PASS1: begin
        sl_a    = a_r[k];
        sl_b    = b_r[k];
        sl_ainv = dec_ainv;
        sl_binv = dec_binv;
        sl_cin  = cin_k;
        sl_op   = dec_op;
      end
      S_PASS2: begin
        sl_a    = a_r[k];
        sl_b    = b_r[k];
        sl_binv = 1'b1;
        sl_cin  = cin_k;
        sl_less = (k == '0) ? lt : 1'b0;
        sl_op   = 2'b11;
      end
      default: ;
    endcase
  end

  // Datapath: operand latch, bit counter, carry chain, result assembly, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= '0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      result    <= '0;
      lt        <= 1'b0;
      carry     <= 1'b0;
      res_valid <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r       <= a;
            b_r       <= b;
            op_r      <= op_sel;
            k         <= '0;
            lt        <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
            res_valid <= op_rsv;
            if (op_rsv) result <= '0;
          end
        end
        S_PASS1: begin
          result[k] <= sl_r;
          carry     <= sl_cout;
          k         <= k_last ? '0 : k + 1'b1;
          if (k_last) begin
            overflow  <= is_arith && sl_ovf;
            carry_out <= is_arith && sl_cout;
            lt        <= sl_set ^ sl_ovf;
            res_valid <= (op_r != OP_SLT);
          end
        end
        S_PASS2: begin
          result[k] <= sl_r;
          carry     <= sl_cout;
          k         <= k_last ? '0 : k + 1'b1;
          if (k_last) res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: behavioural 1-bit slice, directed vector table,
// randomized ops against an arithmetic reference model, back-to-back and
// asynchronous reset sequences.
module tb_alu_serial_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op_sel = 3'b000;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ready, zero, overflow, carry_out, done;
  logic [WIDTH-1:0] result;
  logic             sl_a, sl_b, sl_ainv, sl_binv, sl_cin, sl_less;
  logic [1:0]       sl_op;
  logic             sl_r, sl_cout, sl_set, sl_ovf;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .op_sel(op_sel),
    .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
    .carry_out(carry_out), .done(done),
    .sl_a(sl_a), .sl_b(sl_b), .sl_ainv(sl_ainv), .sl_binv(sl_binv),
    .sl_cin(sl_cin), .sl_less(sl_less), .sl_op(sl_op),
    .sl_r(sl_r), .sl_cout(sl_cout), .sl_set(sl_set), .sl_ovf(sl_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Classic 1-bit ALU slice (invertible inputs, full adder, less passthrough).
  logic s_aa, s_bb, s_sum;
  assign s_aa    = sl_a ^ sl_ainv;
  assign s_bb    = sl_b ^ sl_binv;
  assign s_sum   = s_aa ^ s_bb ^ sl_cin;
  assign sl_cout = (s_aa & s_bb) | (s_aa & sl_cin) | (s_bb & sl_cin);
  assign sl_set  = s_sum;
  assign sl_ovf  = sl_cin ^ sl_cout;
  assign sl_r    = (sl_op == 2'b00) ? (s_aa & s_bb) :
                   (sl_op == 2'b01) ? (s_aa | s_bb) :
                   (sl_op == 2'b10) ? s_sum : sl_less;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] r;
    logic        z;
    logic        ov;
    logic        co;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] sl_bus();
    return {sl_a, sl_b, sl_ainv, sl_binv, sl_cin, sl_less, sl_op};
  endfunction

  // Reference: plain two's-complement arithmetic on whole words.
  function automatic void model(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                                output logic [31:0] r, output logic z, output logic ov,
                                output logic co, output int lat);
    logic [32:0] s;
    r = '0; ov = 1'b0; co = 1'b0; lat = WIDTH + 1;
    case (op)
      3'b000: r = va & vb;
      3'b001: r = va | vb;
      3'b100: r = ~(va | vb);
      3'b010: begin
        s  = {1'b0, va} + {1'b0, vb};
        r  = s[31:0];
        co = s[32];
        ov = (va[31] == vb[31]) && (r[31] != va[31]);
      end
      3'b110, 3'b111: begin
        s  = {1'b0, va} + {1'b0, ~vb} + 33'd1;
        co = s[32];
        ov = (va[31] != vb[31]) && (s[31] != va[31]);
        if (op == 3'b110) r = s[31:0];
        else begin
          r   = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          lat = 2 * WIDTH + 1;
        end
      end
      default: lat = 1;
    endcase
    z = (r == '0);
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic launch(input logic [2:0] vop, input logic [31:0] va, input logic [31:0] vb,
                        output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    op_sel = vop; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    op_sel = 3'($urandom);
  endtask

  // Latency counts the accept cycle as cycle 1.
  task automatic wait_done(output int lat, output bit ok);
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] vop, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] r, output logic z, output logic ov, output logic co,
                        output int lat, output bit ok, output logic [7:0] slb,
                        output logic done_next);
    bit ok1, ok2;
    launch(vop, va, vb, ok1);
    wait_done(lat, ok2);
    ok  = ok1 && ok2;
    r   = result; z = zero; ov = overflow; co = carry_out;
    slb = sl_bus();
    @(negedge clk);
    done_next = done;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, er, va, vb;
    logic        z, ov, co, ez, eov, eco, dn, any_done;
    logic [2:0]  op;
    logic [7:0]  slb;
    int          lat, elat;
    bit          ok;
    longint      t1, t2;

    vecs[0]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 33};
    vecs[1]  = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 33};
    vecs[2]  = '{3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b1, 65};
    vecs[3]  = '{3'b111, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 65};
    // F0F0F0F0 | 0F0F0F00 = FFFFFFF0, so NOR leaves only the low nibble set.
    vecs[4]  = '{3'b100, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 1'b0, 1'b0, 1'b0, 33};
    vecs[5]  = '{3'b000, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0, 1'b0, 33};
    vecs[6]  = '{3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 33};
    vecs[7]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'b101, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 33};
    vecs[10] = '{3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33};
    vecs[11] = '{3'b111, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b1, 65};
    vecs[12] = '{3'b111, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b1, 65};

    // Power-on reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {result, zero, overflow, carry_out, done, sl_bus()}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {ready, done}, 2'b10);

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].va, vecs[i].vb, r, z, ov, co, lat, ok, slb, dn);
      check($sformatf("vec%0d_completed", i), ok, 1'b1);
      check($sformatf("vec%0d_result", i), r, vecs[i].r);
      check($sformatf("vec%0d_zero", i), z, vecs[i].z);
      check($sformatf("vec%0d_overflow", i), ov, vecs[i].ov);
      check($sformatf("vec%0d_carry_out", i), co, vecs[i].co);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_slice_idle_in_done", i), slb, 8'd0);
      check($sformatf("vec%0d_done_one_cycle", i), {dn, ready}, 2'b01);
      a = $urandom; b = $urandom; op_sel = 3'($urandom);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_hold", i), {result, zero, overflow, carry_out},
            {vecs[i].r, vecs[i].z, vecs[i].ov, vecs[i].co});
    end

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      va = $urandom;
      vb = $urandom;
      if ($urandom_range(0, 3) == 0) va = $urandom_range(0, 1) ? 32'h80000000 : 32'h7FFFFFFF;
      if ($urandom_range(0, 5) == 0) vb = va;
      model(op, va, vb, er, ez, eov, eco, elat);
      run_op(op, va, vb, r, z, ov, co, lat, ok, slb, dn);
      check($sformatf("rnd%0d_op%0b_a%0h_b%0h", n, op, va, vb),
            {ok, r, z, ov, co, lat[7:0]}, {1'b1, er, ez, eov, eco, elat[7:0]});
    end

    // start held high: ops are spaced 34 cycles; mid-op input changes ignored.
    op_sel = 3'b010; a = 32'h12345678; b = 32'h11111111; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h00000002;
    wait_done(lat, ok);
    t1 = cyc;
    check("b2b_first", {ok, result, lat[7:0]}, {1'b1, 32'h23456789, 8'd33});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    a = 32'hDEAD0000; b = 32'h0BAD0000;
    wait_done(lat, ok);
    t2 = cyc;
    start = 1'b0;
    check("b2b_second", {ok, result, carry_out, overflow}, {1'b1, 32'h00000001, 1'b1, 1'b0});
    check("b2b_spacing", t2 - t1, 64'd34);

    // Asynchronous reset in the middle of the first pass (bit 10).
    @(negedge clk);
    launch(3'b010, 32'hFFFFFFFF, 32'h00000000, ok);
    repeat (10) @(posedge clk);
    #2;
    check("midop_before_reset", {ok, result[9:0], sl_op, sl_a}, {1'b1, 10'h3FF, 2'b10, 1'b1});
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", {result, zero, overflow, carry_out, done, sl_bus()}, 64'd0);
    any_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_done = any_done | done;
    end
    check("no_done_in_reset", any_done, 1'b0);
    op_sel = 3'b010; a = 32'd3; b = 32'd4; start = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("accept_first_edge_after_reset", ready, 1'b0);
    wait_done(lat, ok);
    check("after_reset_op", {ok, result, zero, overflow, carry_out, lat[7:0]},
          {1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 8'd33});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
